qupls4_uop_sequencer: RTL and testbench
=======================================

Name: qupls4_uop_sequencer

Overview:
Producer side of the decoder's instruction input. Accepts fetched instruction words over a valid/ready handshake and presents one micro-op per cycle to the decoder; the decoder's en signal acts as out_ready.
- Ordinary instructions pass through as a single micro-op.
- Macro instructions PUSHM/POPM expand into a sequence of store/load micro-ops plus one stack-pointer adjust.

Parameters:
INS_W, 48, instruction / micro-op width
SP_REG, 31, architectural stack-pointer register number
WORD_BYTES, 8, byte stride per pushed/popped register

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard in-progress expansion and output
in_valid  in  1  fetch word valid
in_ready  out  1  sequencer accepts in_ins this cycle
in_ip  in  64  address of in_ins
in_ins  in  INS_W  fetched instruction
out_v  out  1  micro-op valid
out_ready  in  1  decoder consumes (decoder en)
out_ip  out  64  ip of parent instruction
out_uop  out  INS_W  micro-op
out_idx  out  4  micro-op index within parent
out_last  out  1  final micro-op of parent
out_macro  out  1  micro-op came from expansion

Behaviour:
- Field layout, instruction and micro-op words:
  - op[6:0], Rd[12:7], Rs1[18:13], imm16[34:19], [47:35] zero.
  - For macros: Rfirst = in_ins[12:7], N = in_ins[16:13] (0..15).
- Reset outputs: out_v=0, out_uop=0, out_ip=0, out_idx=0, out_last=0, out_macro=0. State IDLE, cnt=0.
- Priority: rst > flush > advance.
- Definitions:
  - adv = !out_v | out_ready.
  - in_ready = (state==IDLE) & adv & !flush. This path is combinational from out_ready.
- IDLE, handshake (in_valid & in_ready):
  - Non-macro: out_uop=in_ins, out_idx=0, out_last=1, out_macro=0. One-cycle latency.
  - Macro: latch kind, ip, Rfirst, N. Emit uop 0. TOTAL = N+1.
    - If N==0: out_last=1, stay IDLE.
    - Else: cnt=1, go EXPAND.
- IDLE, no handshake with adv: out_v←0.
- EXPAND: on adv, emit uop cnt and cnt++. When cnt==TOTAL-1, set out_last=1 and go IDLE. Without adv, hold all outputs stable.
- PUSHM expansion:
  - uop0 = ADDI Rd=SP, Rs1=SP, imm = -(WORD_BYTES*N).
  - uop i (1..N) = STO Rd=(Rfirst+i-1) mod 64, Rs1=SP, imm = WORD_BYTES*(i-1).
- POPM expansion:
  - uop i (0..N-1) = LDO Rd=(Rfirst+i) mod 64, Rs1=SP, imm = WORD_BYTES*i.
  - uop N = ADDI SP, SP, +WORD_BYTES*N.
- Arithmetic: immediates are 16-bit two's complement. Register number wraps modulo 64.
- flush: out_v←0, state←IDLE, cnt←0 on the next edge. An in-flight expansion is abandoned. No input is accepted in the flush cycle.
- An output held with out_v=1 and out_ready=0 must not change (stall-stable).
- Reset mid-expansion behaves like flush, and outputs return to their reset values.

Optional Feature:
QUPLS4_UOPSEQ_STATS_EN
- Defined: adds output ports stat_macros[31:0] and stat_uops[31:0].
  - stat_macros increments on each accepted macro.
  - stat_uops increments on each out_v&out_ready.
  - Both are cleared by rst, not by flush, and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Qupls4_pkg gains:
  - OP_PUSHM=7'h58, OP_POPM=7'h59, OP_STO=7'h4B, OP_LDO=7'h43, OP_ADDI=7'h04.
  - typedef uopseq_state_t {IDLE, EXPAND}.
  - typedef macro_kind_t {MK_PUSHM, MK_POPM}.
- Sub-module qupls4_uop_gen (combinational): inputs kind, Rfirst, N, idx; output micro-op word. The sequencer owns all state.

Test Plan:
- Passthrough: in_ins op=7'h10, out_ready=1 → next cycle out_v=1, out_uop==in_ins, out_last=1, out_macro=0, in_ready stays 1 for back-to-back.
- PUSHM Rfirst=5, N=3, SP=31 → uops, out_last on the 4th only, in_ready=0 for three cycles:
  - ADDI r31,r31,imm 16'hFFE8
  - STO r5,[r31+0]
  - STO r6,[r31+8]
  - STO r7,[r31+16]
- POPM Rfirst=62, N=3 → uops:
  - LDO r62,[+0]
  - LDO r63,[+8]
  - LDO r0,[+16]
  - ADDI r31,r31,+24 (register wrap)
- Stall: PUSHM N=2 with out_ready=0 for 5 cycles at idx 1 → out_uop/out_idx stable; then ready → idx 2 with out_last=1.
- Flush at idx 1 of POPM N=4 → next cycle out_v=0, in_ready=1; next instruction passes through with idx 0.
- N=0 PUSHM → single ADDI imm 0, out_last=1; with STATS_EN: stat_macros=1, stat_uops=1.

Source files
------------

// File: rtl/qupls4_pkg.sv
// Shared opcodes and type definitions for the qupls4 decode front end.
package qupls4_pkg;

    localparam logic [6:0] OP_PUSHM = 7'h58;
    localparam logic [6:0] OP_POPM  = 7'h59;
    localparam logic [6:0] OP_STO   = 7'h4B;
    localparam logic [6:0] OP_LDO   = 7'h43;
    localparam logic [6:0] OP_ADDI  = 7'h04;

    typedef enum logic {IDLE, EXPAND} uopseq_state_t;
    typedef enum logic {MK_PUSHM, MK_POPM} macro_kind_t;

    function automatic logic is_macro_op(input logic [6:0] op);
        return (op == OP_PUSHM) || (op == OP_POPM);
    endfunction

endpackage

// File: rtl/qupls4_uop_gen.sv
// Combinational micro-op builder for PUSHM/POPM expansion; produces the
// micro-op word for a given expansion index.
module qupls4_uop_gen
    import qupls4_pkg::*;
#(
    parameter int INS_W      = 48,
    parameter int SP_REG     = 31,
    parameter int WORD_BYTES = 8
) (
    input  macro_kind_t      kind,
    input  logic [5:0]       rfirst,
    input  logic [3:0]       n,
    input  logic [3:0]       idx,
    output logic [INS_W-1:0] uop
);

    logic [6:0]  op;
    logic [5:0]  rd;
    logic [5:0]  sp;
    logic [15:0] stride;
    logic [15:0] off_idx;
    logic [15:0] off_n;
    logic [15:0] imm;

    always_comb begin
        sp      = 6'(SP_REG);
        stride  = 16'(WORD_BYTES);
        off_idx = stride * {12'd0, idx};
        off_n   = stride * {12'd0, n};
        op      = OP_ADDI;
        rd      = sp;
        imm     = '0;
        if (kind == MK_PUSHM) begin
            // Stack pointer drops first, then registers store upward from it.
            if (idx == 4'd0) begin
                op  = OP_ADDI;
                rd  = sp;
                imm = 16'd0 - off_n;
            end else begin
                op  = OP_STO;
                rd  = rfirst + {2'b00, idx} - 6'd1;
                imm = off_idx - stride;
            end
        end else begin
            if (idx == n) begin
                op  = OP_ADDI;
                rd  = sp;
                imm = off_n;
            end else begin
                op  = OP_LDO;
                rd  = rfirst + {2'b00, idx};
                imm = off_idx;
            end
        end
        uop        = '0;
        uop[6:0]   = op;
        uop[12:7]  = rd;
        uop[18:13] = sp;
        uop[34:19] = imm;
    end

endmodule

// File: rtl/qupls4_uop_sequencer.sv
// Feeds the decoder one micro-op per cycle, expanding PUSHM/POPM macros.
// Optional build macro QUPLS4_UOPSEQ_STATS_EN adds macro/uop counters.
module qupls4_uop_sequencer
    import qupls4_pkg::*;
#(
    parameter int INS_W      = 48,
    parameter int SP_REG     = 31,
    parameter int WORD_BYTES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_ip,
    input  logic [INS_W-1:0] in_ins,
    output logic             out_v,
    input  logic             out_ready,
    output logic [63:0]      out_ip,
    output logic [INS_W-1:0] out_uop,
    output logic [3:0]       out_idx,
    output logic             out_last,
    output logic             out_macro
`ifdef QUPLS4_UOPSEQ_STATS_EN
    ,
    output logic [31:0]      stat_macros,
    output logic [31:0]      stat_uops
`endif
);

    uopseq_state_t    state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       n_q, n_d;
    logic [5:0]       rfirst_q, rfirst_d;
    macro_kind_t      kind_q, kind_d;
    logic             out_v_q, out_v_d;
    logic [63:0]      out_ip_q, out_ip_d;
    logic [INS_W-1:0] out_uop_q, out_uop_d;
    logic [3:0]       out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             out_macro_q, out_macro_d;
`ifdef QUPLS4_UOPSEQ_STATS_EN
    logic [31:0]      stat_macros_q, stat_macros_d;
    logic [31:0]      stat_uops_q, stat_uops_d;
`endif

    logic             adv;
    logic             hs;
    logic             in_is_macro;
    macro_kind_t      in_kind;
    macro_kind_t      g_kind;
    logic [5:0]       g_rfirst;
    logic [3:0]       g_n;
    logic [3:0]       g_idx;
    logic [INS_W-1:0] g_uop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            rfirst_q    <= '0;
            kind_q      <= MK_PUSHM;
            out_v_q     <= 1'b0;
            out_ip_q    <= '0;
            out_uop_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_macro_q <= 1'b0;
`ifdef QUPLS4_UOPSEQ_STATS_EN
            stat_macros_q <= '0;
            stat_uops_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            rfirst_q    <= rfirst_d;
            kind_q      <= kind_d;
            out_v_q     <= out_v_d;
            out_ip_q    <= out_ip_d;
            out_uop_q   <= out_uop_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_macro_q <= out_macro_d;
`ifdef QUPLS4_UOPSEQ_STATS_EN
            stat_macros_q <= stat_macros_d;
            stat_uops_q   <= stat_uops_d;
`endif
        end
    end

    // In IDLE the generator sees the incoming word so uop 0 issues on acceptance.
    always_comb begin
        in_kind = (in_ins[6:0] == OP_POPM) ? MK_POPM : MK_PUSHM;
        if (state_q == IDLE) begin
            g_kind   = in_kind;
            g_rfirst = in_ins[12:7];
            g_n      = in_ins[16:13];
            g_idx    = 4'd0;
        end else begin
            g_kind   = kind_q;
            g_rfirst = rfirst_q;
            g_n      = n_q;
            g_idx    = cnt_q;
        end
    end

    qupls4_uop_gen #(
        .INS_W      (INS_W),
        .SP_REG     (SP_REG),
        .WORD_BYTES (WORD_BYTES)
    ) u_gen (
        .kind   (g_kind),
        .rfirst (g_rfirst),
        .n      (g_n),
        .idx    (g_idx),
        .uop    (g_uop)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        rfirst_d    = rfirst_q;
        kind_d      = kind_q;
        out_v_d     = out_v_q;
        out_ip_d    = out_ip_q;
        out_uop_d   = out_uop_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_macro_d = out_macro_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_v_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        out_v_d   = 1'b1;
                        out_ip_d  = in_ip;
                        out_idx_d = 4'd0;
                        if (in_is_macro) begin
                            kind_d      = in_kind;
                            rfirst_d    = in_ins[12:7];
                            n_d         = in_ins[16:13];
                            out_uop_d   = g_uop;
                            out_macro_d = 1'b1;
                            if (in_ins[16:13] == 4'd0) begin
                                out_last_d = 1'b1;
                            end else begin
                                out_last_d = 1'b0;
                                cnt_d      = 4'd1;
                                state_d    = EXPAND;
                            end
                        end else begin
                            out_uop_d   = in_ins;
                            out_last_d  = 1'b1;
                            out_macro_d = 1'b0;
                        end
                    end else if (adv) begin
                        out_v_d = 1'b0;
                    end
                end
                EXPAND: begin
                    if (adv) begin
                        out_v_d     = 1'b1;
                        out_uop_d   = g_uop;
                        out_idx_d   = cnt_q;
                        out_macro_d = 1'b1;
                        if (cnt_q == n_q) begin
                            out_last_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            out_last_d = 1'b0;
                            cnt_d      = cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef QUPLS4_UOPSEQ_STATS_EN
        stat_macros_d = stat_macros_q + ((hs && in_is_macro) ? 32'd1 : 32'd0);
        stat_uops_d   = stat_uops_q + ((out_v_q && out_ready) ? 32'd1 : 32'd0);
`endif
    end

    always_comb begin
        adv         = !out_v_q || out_ready;
        in_ready    = (state_q == IDLE) && adv && !flush;
        hs          = in_valid && in_ready;
        in_is_macro = is_macro_op(in_ins[6:0]);
        out_v       = out_v_q;
        out_ip      = out_ip_q;
        out_uop     = out_uop_q;
        out_idx     = out_idx_q;
        out_last    = out_last_q;
        out_macro   = out_macro_q;
`ifdef QUPLS4_UOPSEQ_STATS_EN
        stat_macros = stat_macros_q;
        stat_uops   = stat_uops_q;
`endif
    end

endmodule

// File: tb/tb_qupls4_uop_sequencer.sv
// Self-checking bench for qupls4_uop_sequencer: queue-based reference model
// of the micro-op stream plus directed literal checks and random traffic.
module tb_qupls4_uop_sequencer;

    localparam int INS_W = 48;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_ip;
    logic [INS_W-1:0] in_ins;
    logic             out_v;
    logic             out_ready;
    logic [63:0]      out_ip;
    logic [INS_W-1:0] out_uop;
    logic [3:0]       out_idx;
    logic             out_last;
    logic             out_macro;
`ifdef QUPLS4_UOPSEQ_STATS_EN
    logic [31:0]      stat_macros;
    logic [31:0]      stat_uops;
`endif

    always #5 clk = ~clk;

    qupls4_uop_sequencer #(
        .INS_W      (INS_W),
        .SP_REG     (31),
        .WORD_BYTES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ip     (in_ip),
        .in_ins    (in_ins),
        .out_v     (out_v),
        .out_ready (out_ready),
        .out_ip    (out_ip),
        .out_uop   (out_uop),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_macro (out_macro)
`ifdef QUPLS4_UOPSEQ_STATS_EN
        ,
        .stat_macros (stat_macros),
        .stat_uops   (stat_uops)
`endif
    );

    typedef struct {
        logic [47:0] uop;
        logic [63:0] ip;
        logic [3:0]  idx;
        logic        last;
        logic        macro;
    } uop_t;

    uop_t        q[$];
    uop_t        cur;
    bit          cur_v;
    bit          zero_chk;
    int unsigned m_macros;
    int unsigned m_uops;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] mk(input int op, input int rd, input int rs1, input int imm);
        logic [47:0] w;
        w         = '0;
        w[6:0]    = op[6:0];
        w[12:7]   = rd[5:0];
        w[18:13]  = rs1[5:0];
        w[34:19]  = imm[15:0];
        return w;
    endfunction

    function automatic logic [47:0] mkmacro(input int op, input int rf, input int n);
        logic [47:0] w;
        w         = '0;
        w[6:0]    = op[6:0];
        w[12:7]   = rf[5:0];
        w[16:13]  = n[3:0];
        return w;
    endfunction

    // Expected micro-op list for one accepted instruction, straight from the ISA rules.
    task automatic expand(input logic [47:0] ins, input logic [63:0] ip);
        int   op;
        int   rf;
        int   n;
        uop_t u;
        op = int'(ins[6:0]);
        if (op == 'h58 || op == 'h59) begin
            rf = int'(ins[12:7]);
            n  = int'(ins[16:13]);
            for (int i = 0; i <= n; i++) begin
                if (op == 'h58)
                    u.uop = (i == 0) ? mk('h04, 31, 31, (65536 - 8 * n) % 65536)
                                     : mk('h4B, (rf + i - 1) % 64, 31, 8 * (i - 1));
                else
                    u.uop = (i < n) ? mk('h43, (rf + i) % 64, 31, 8 * i)
                                    : mk('h04, 31, 31, 8 * n);
                u.ip    = ip;
                u.idx   = 4'(i);
                u.last  = (i == n);
                u.macro = 1'b1;
                q.push_back(u);
            end
        end else begin
            u.uop   = ins;
            u.ip    = ip;
            u.idx   = 4'd0;
            u.last  = 1'b1;
            u.macro = 1'b0;
            q.push_back(u);
        end
    endtask

    function automatic bit mdl_in_ready();
        return (q.size() == 0) && (!cur_v || out_ready) && !flush;
    endfunction

    task automatic model_edge();
        bit rdy;
        rdy = mdl_in_ready();
        if (rst) begin
            q.delete();
            cur_v     = 1'b0;
            cur.uop   = '0;
            cur.ip    = '0;
            cur.idx   = '0;
            cur.last  = 1'b0;
            cur.macro = 1'b0;
            m_macros  = 0;
            m_uops    = 0;
            return;
        end
        if (cur_v && out_ready) m_uops++;
        if (flush) begin
            cur_v = 1'b0;
            q.delete();
            return;
        end
        if (!cur_v || out_ready) begin
            if (q.size() > 0) begin
                cur   = q.pop_front();
                cur_v = 1'b1;
            end else if (in_valid && rdy) begin
                expand(in_ins, in_ip);
                cur   = q.pop_front();
                cur_v = 1'b1;
                if (cur.macro) m_macros++;
            end else begin
                cur_v = 1'b0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("out_v", 64'(out_v), 64'(cur_v));
        if (cur_v || zero_chk) begin
            check("out_uop", 64'(out_uop), 64'(cur.uop));
            check("out_ip", out_ip, cur.ip);
            check("out_idx", 64'(out_idx), 64'(cur.idx));
            check("out_last", 64'(out_last), 64'(cur.last));
            check("out_macro", 64'(out_macro), 64'(cur.macro));
        end
`ifdef QUPLS4_UOPSEQ_STATS_EN
        check("stat_macros", 64'(stat_macros), 64'(m_macros));
        check("stat_uops", 64'(stat_uops), 64'(m_uops));
`endif
    endtask

    // exp_rdy < 0 means no literal in_ready expectation for this cycle.
    task automatic step(input int exp_rdy);
        #1;
        if (!rst) begin
            check("in_ready", 64'(in_ready), 64'(mdl_in_ready()));
            if (exp_rdy >= 0) check("in_ready_lit", 64'(in_ready), 64'(exp_rdy));
        end
        @(posedge clk);
        model_edge();
        zero_chk = rst;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic drive(input logic v, input logic [47:0] ins, input logic [63:0] ip);
        in_valid = v;
        in_ins   = ins;
        in_ip    = ip;
    endtask

    task automatic lit_uop(input string name, input logic [47:0] exp_uop, input int exp_idx, input int exp_last);
        check({name, "_uop"}, 64'(out_uop), 64'(exp_uop));
        check({name, "_idx"}, 64'(out_idx), 64'(exp_idx));
        check({name, "_last"}, 64'(out_last), 64'(exp_last));
    endtask

    initial begin
        logic [47:0] w;
        cur_v    = 1'b0;
        zero_chk = 1'b0;
        m_macros = 0;
        m_uops   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0);
        step(-1);
        step(-1);
        check("rst_out_v", 64'(out_v), 64'd0);
        check("rst_out_uop", 64'(out_uop), 64'd0);
        rst = 1'b0;

        // Passthrough, back-to-back
        w = 48'h0000_1234_5690;
        drive(1'b1, w, 64'h1000);
        step(1);
        check("pass_uop", 64'(out_uop), 64'(w));
        check("pass_last", 64'(out_last), 64'd1);
        check("pass_macro", 64'(out_macro), 64'd0);
        drive(1'b1, 48'h0000_0000_0A10, 64'h1006);
        step(1);
        check("pass2_ip", out_ip, 64'h1006);

        // PUSHM r5, N=3
        drive(1'b1, mkmacro('h58, 5, 3), 64'h2000);
        step(1);
        lit_uop("push0", mk('h04, 31, 31, 'hFFE8), 0, 0);
        drive(1'b0, '0, '0);
        step(0);
        lit_uop("push1", mk('h4B, 5, 31, 0), 1, 0);
        step(0);
        lit_uop("push2", mk('h4B, 6, 31, 8), 2, 0);
        step(0);
        lit_uop("push3", mk('h4B, 7, 31, 16), 3, 1);
        step(1);

        // POPM r62, N=3 with register wrap
        drive(1'b1, mkmacro('h59, 62, 3), 64'h3000);
        step(1);
        lit_uop("pop0", mk('h43, 62, 31, 0), 0, 0);
        drive(1'b0, '0, '0);
        step(0);
        lit_uop("pop1", mk('h43, 63, 31, 8), 1, 0);
        step(0);
        lit_uop("pop2", mk('h43, 0, 31, 16), 2, 0);
        step(0);
        lit_uop("pop3", mk('h04, 31, 31, 24), 3, 1);
        step(1);

        // Stall at idx 1 of PUSHM N=2
        drive(1'b1, mkmacro('h58, 10, 2), 64'h4000);
        step(1);
        drive(1'b0, '0, '0);
        step(0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0);
            lit_uop("stall", mk('h4B, 10, 31, 0), 1, 0);
        end
        out_ready = 1'b1;
        step(0);
        lit_uop("unstall", mk('h4B, 11, 31, 8), 2, 1);
        step(1);

        // Flush at idx 1 of POPM N=4
        drive(1'b1, mkmacro('h59, 1, 4), 64'h5000);
        step(1);
        drive(1'b0, '0, '0);
        step(0);
        check("flush_pre_idx", 64'(out_idx), 64'd1);
        flush = 1'b1;
        step(0);
        flush = 1'b0;
        check("flush_out_v", 64'(out_v), 64'd0);
        drive(1'b1, 48'h0000_0000_0290, 64'h5100);
        step(1);
        lit_uop("after_flush", 48'h0000_0000_0290, 0, 1);
        check("after_flush_macro", 64'(out_macro), 64'd0);

        // N=0 PUSHM from a clean reset
        rst = 1'b1;
        step(-1);
        rst = 1'b0;
        drive(1'b1, mkmacro('h58, 3, 0), 64'h6000);
        step(1);
        lit_uop("n0", mk('h04, 31, 31, 0), 0, 1);
        drive(1'b0, '0, '0);
        step(1);
`ifdef QUPLS4_UOPSEQ_STATS_EN
        check("n0_stat_macros", 64'(stat_macros), 64'd1);
        check("n0_stat_uops", 64'(stat_uops), 64'd1);
`endif

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            int sel;
            w   = {$urandom, $urandom};
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      w[6:0] = 7'h58;
            else if (sel < 6) w[6:0] = 7'h59;
            drive(($urandom_range(0, 9) < 7), w, {$urandom, $urandom});
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 199) == 0);
            step(-1);
        end
        rst   = 1'b0;
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
